// File: rtl/dht11_poll_scheduler.sv
// DHT11 measurement sequencer: issues periodic/one-shot engine starts, times them out,
// validates the frame checksum, retries after a hold-off and latches good readings.
module dht11_poll_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_MS = 10,
  parameter int RETRY_MS   = 1000,
  parameter int MAX_RETRY  = 3,
  parameter int MIN_PER_MS = 1000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cfg_enable,
  input  logic        cfg_oneshot,
  input  logic [15:0] cfg_period_ms,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        eng_error,
  input  logic [39:0] eng_data,
  output logic [7:0]  hum_int,
  output logic [7:0]  hum_dec,
  output logic [7:0]  tmp_int,
  output logic [7:0]  tmp_dec,
  output logic        data_valid,
  output logic        sts_busy,
  output logic        sts_fail,
  output logic [7:0]  sts_err_cnt,
  output logic        irq
);

  localparam int DIV = (CLK_HZ >= 2000) ? CLK_HZ / 1000 : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CHECK, S_FAIL, S_HOLD, S_PERIOD
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_ms_cnt;
  logic [15:0]   r_per;
  logic [RW-1:0] r_retry;
  logic          r_en_q;
  logic          r_abort;
  logic [39:0]   r_frame;
  logic          r_frame_err;
  logic          r_eng_start, r_irq, r_data_valid, r_sts_fail;
  logic [7:0]    r_hum_int, r_hum_dec, r_tmp_int, r_tmp_dec, r_err_cnt;

  logic          w_tick, w_en_rise, w_en_fall;
  logic [15:0]   w_per_clamped;

  function automatic logic frame_ok(input logic [39:0] f, input logic err);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (!err) && (s == f[7:0]);
  endfunction

  assign w_tick        = (r_pre == PW'(DIV - 1));
  assign w_en_rise     = cfg_enable & ~r_en_q;
  assign w_en_fall     = ~cfg_enable & r_en_q;
  assign w_per_clamped = (cfg_period_ms < 16'(MIN_PER_MS)) ? 16'(MIN_PER_MS) : cfg_period_ms;

  // Free-running millisecond prescaler
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Measurement sequencer with registered status/engine outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_ms_cnt     <= 16'd0;
      r_per        <= 16'd0;
      r_retry      <= '0;
      r_en_q       <= 1'b0;
      r_abort      <= 1'b0;
      r_frame      <= 40'd0;
      r_frame_err  <= 1'b0;
      r_eng_start  <= 1'b0;
      r_irq        <= 1'b0;
      r_data_valid <= 1'b0;
      r_sts_fail   <= 1'b0;
      r_hum_int    <= 8'd0;
      r_hum_dec    <= 8'd0;
      r_tmp_int    <= 8'd0;
      r_tmp_dec    <= 8'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_en_q      <= cfg_enable;
      r_eng_start <= 1'b0;
      r_irq       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (cfg_oneshot || w_en_rise) begin
            r_state     <= S_START;
            r_eng_start <= 1'b1;
          end
        end
        S_START: begin
          r_ms_cnt <= 16'd0;
          r_state  <= S_WAIT;
          if (w_en_fall) r_abort <= 1'b1;
        end
        S_WAIT: begin
          if (w_en_fall) r_abort <= 1'b1;
          // A done arriving on the timeout tick still counts as a response
          if (eng_done) begin
            r_frame     <= eng_data;
            r_frame_err <= eng_error;
            r_state     <= S_CHECK;
          end else if (w_tick) begin
            if (r_ms_cnt == 16'(TIMEOUT_MS - 1)) r_state <= S_FAIL;
            else r_ms_cnt <= r_ms_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (frame_ok(r_frame, r_frame_err)) begin
            r_hum_int    <= r_frame[39:32];
            r_hum_dec    <= r_frame[31:24];
            r_tmp_int    <= r_frame[23:16];
            r_tmp_dec    <= r_frame[15:8];
            r_data_valid <= 1'b1;
            r_sts_fail   <= 1'b0;
            r_irq        <= 1'b1;
            r_retry      <= '0;
            r_abort      <= 1'b0;
            r_ms_cnt     <= 16'd0;
            r_per        <= w_per_clamped;
            r_state      <= cfg_enable ? S_PERIOD : S_IDLE;
          end else begin
            if (w_en_fall) r_abort <= 1'b1;
            r_state <= S_FAIL;
          end
        end
        S_FAIL: begin
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          r_ms_cnt <= 16'd0;
          if ((r_retry < RW'(MAX_RETRY)) && !r_abort) begin
            r_retry <= r_retry + RW'(1);
            r_state <= S_HOLD;
          end else begin
            // An attempt cut short by enable dropping is not an exhausted measurement
            if (!r_abort) begin
              r_sts_fail <= 1'b1;
              r_irq      <= 1'b1;
            end
            r_retry <= '0;
            r_abort <= 1'b0;
            r_per   <= w_per_clamped;
            r_state <= cfg_enable ? S_PERIOD : S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_en_fall) begin
            r_retry <= '0;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_ms_cnt == 16'(RETRY_MS - 1)) begin
              r_state     <= S_START;
              r_eng_start <= 1'b1;
            end else begin
              r_ms_cnt <= r_ms_cnt + 16'd1;
            end
          end else begin
            r_ms_cnt <= r_ms_cnt;
          end
        end
        S_PERIOD: begin
          if (w_en_fall) begin
            r_retry <= '0;
            r_state <= S_IDLE;
          end else if (cfg_oneshot) begin
            r_state     <= S_START;
            r_eng_start <= 1'b1;
          end else if (w_tick) begin
            if (r_ms_cnt == r_per - 16'd1) begin
              r_state     <= S_START;
              r_eng_start <= 1'b1;
            end else begin
              r_ms_cnt <= r_ms_cnt + 16'd1;
            end
          end else begin
            r_ms_cnt <= r_ms_cnt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eng_start   = r_eng_start;
  assign irq         = r_irq;
  assign hum_int     = r_hum_int;
  assign hum_dec     = r_hum_dec;
  assign tmp_int     = r_tmp_int;
  assign tmp_dec     = r_tmp_dec;
  assign data_valid  = r_data_valid;
  assign sts_fail    = r_sts_fail;
  assign sts_err_cnt = r_err_cnt;
  assign sts_busy    = (r_state != S_IDLE) && (r_state != S_PERIOD);

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Directed/randomised bench for dht11_poll_scheduler with an engine BFM and
// a reading/status reference model derived from the measurement rules.
module tb_dht11_poll_scheduler;

  localparam int CLK_HZ = 10000, TIMEOUT_MS = 3, RETRY_MS = 2, MAX_RETRY = 3, MIN_PER_MS = 4;

  logic        ACLK = 1'b0, ARESETN = 1'b0, cfg_enable = 1'b0, cfg_oneshot = 1'b0;
  logic [15:0] cfg_period_ms = 16'd0;
  logic        eng_start, eng_done, eng_error;
  logic [39:0] eng_data;
  logic [7:0]  hum_int, hum_dec, tmp_int, tmp_dec, sts_err_cnt;
  logic        data_valid, sts_busy, sts_fail, irq;

  dht11_poll_scheduler #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .RETRY_MS(RETRY_MS),
                         .MAX_RETRY(MAX_RETRY), .MIN_PER_MS(MIN_PER_MS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
    .cfg_period_ms(cfg_period_ms), .eng_start(eng_start), .eng_done(eng_done),
    .eng_error(eng_error), .eng_data(eng_data), .hum_int(hum_int), .hum_dec(hum_dec),
    .tmp_int(tmp_int), .tmp_dec(tmp_dec), .data_valid(data_valid), .sts_busy(sts_busy),
    .sts_fail(sts_fail), .sts_err_cnt(sts_err_cnt), .irq(irq));

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          respond;
    bit          at_to;
    bit          err;
    logic [39:0] data;
    int          dly;
  } rsp_t;

  rsp_t rq[$];
  int   q_start[$], q_done[$];
  int   cyc = 0, tb_k = 0, n_start = 0, start_cyc = 0, done_cyc = 0, irq_cnt = 0, irq_cyc = 0;
  int   checks = 0, errors = 0;

  logic [7:0] e_hi, e_hd, e_ti, e_td, e_err;
  logic       e_valid, e_fail;

  always @(posedge ACLK) cyc <= cyc + 1;

  // ms ticks fall on every 10th clock after reset release
  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) tb_k <= 0;
    else tb_k <= tb_k + 1;

  always @(negedge ACLK)
    if (irq) begin
      irq_cnt <= irq_cnt + 1;
      irq_cyc <= cyc;
    end

  // Engine BFM: answers each start from the response queue
  initial begin
    rsp_t r;
    int   t;
    eng_done = 1'b0; eng_error = 1'b0; eng_data = 40'd0;
    forever begin
      @(negedge ACLK);
      if (ARESETN && eng_start) begin
        n_start++;
        start_cyc = cyc;
        q_start.push_back(cyc);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          if (r.respond) begin
            if (r.at_to) begin
              t = 0;
              while (t < TIMEOUT_MS) begin
                @(negedge ACLK);
                if (tb_k % 10 == 9) t++;
              end
            end else begin
              repeat (r.dly) @(negedge ACLK);
            end
            eng_data = r.data; eng_error = r.err; eng_done = 1'b1;
            done_cyc = cyc;
            q_done.push_back(cyc);
            @(negedge ACLK);
            eng_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hum_int"}, hum_int, e_hi);
    check({tag, "_hum_dec"}, hum_dec, e_hd);
    check({tag, "_tmp_int"}, tmp_int, e_ti);
    check({tag, "_tmp_dec"}, tmp_dec, e_td);
    check({tag, "_valid"}, data_valid, e_valid);
    check({tag, "_fail"}, sts_fail, e_fail);
    check({tag, "_errcnt"}, sts_err_cnt, e_err);
  endtask

  function automatic logic [39:0] mk_frame(input logic [31:0] p, input logic [7:0] off);
    logic [7:0] s;
    s = p[31:24] + p[23:16] + p[15:8] + p[7:0] + off;
    return {p, s};
  endfunction

  task automatic model_good(input logic [39:0] d);
    e_hi = d[39:32]; e_hd = d[31:24]; e_ti = d[23:16]; e_td = d[15:8];
    e_valid = 1'b1; e_fail = 1'b0;
  endtask

  task automatic model_errs(input int n);
    e_err = (int'(e_err) + n > 255) ? 8'd255 : 8'(int'(e_err) + n);
  endtask

  task automatic push(input bit respond, input bit at_to, input bit err, input logic [39:0] d, input int dly);
    rsp_t r;
    r.respond = respond; r.at_to = at_to; r.err = err; r.data = d; r.dly = dly;
    rq.push_back(r);
  endtask

  task automatic pulse_oneshot();
    @(negedge ACLK); cfg_oneshot = 1'b1;
    @(negedge ACLK); cfg_oneshot = 1'b0;
  endtask

  task automatic wait_irq(input int prev, input int budget, input string tag);
    int i = 0;
    while (irq_cnt == prev && i < budget) begin
      @(negedge ACLK); #1; i++;
    end
    checks++;
    assert (irq_cnt != prev) else begin
      errors++;
      $error("FAIL %s irq_timeout observed=%0d expected=%0d", tag, irq_cnt, prev + 1);
    end
  endtask

  task automatic wait_start(input int target, input int budget, input string tag);
    int i = 0;
    while (n_start < target && i < budget) begin
      @(negedge ACLK); #1; i++;
    end
    check({tag, "_start_seen"}, 64'(n_start), 64'(target));
  endtask

  task automatic one_good(input string tag, input logic [39:0] d, input int dly);
    int s0, i0;
    s0 = n_start; i0 = irq_cnt;
    push(1'b1, 1'b0, 1'b0, d, dly);
    pulse_oneshot();
    wait_irq(i0, 300, tag);
    check({tag, "_irq_lat"}, 64'(irq_cyc - done_cyc), 64'd2);
    model_good(d);
    check_outputs(tag);
    repeat (3) @(negedge ACLK);
    #1;
    check({tag, "_irq_once"}, 64'(irq_cnt), 64'(i0 + 1));
    check({tag, "_starts"}, 64'(n_start), 64'(s0 + 1));
  endtask

  initial begin
    logic [39:0] g[4];
    logic [39:0] d;
    int s0, i0, ic;
    bit kind;

    e_hi = 8'd0; e_hd = 8'd0; e_ti = 8'd0; e_td = 8'd0; e_err = 8'd0;
    e_valid = 1'b0; e_fail = 1'b0;

    repeat (3) @(negedge ACLK);
    #1;
    check_outputs("reset");
    check("reset_start", eng_start, 1'b0);
    check("reset_busy", sts_busy, 1'b0);
    check("reset_irq", irq, 1'b0);
    @(negedge ACLK); ARESETN = 1'b1;

    // one-shot reads: fixed frame then random frames
    one_good("t1_fixed", 40'h3200_1900_4B, 15);
    for (int k = 0; k < 2; k++) one_good("t1_rand", mk_frame($urandom, 8'd0), $urandom_range(1, 18));

    // periodic polling, clamp, and period sampled at entry
    s0 = n_start; i0 = irq_cnt;
    for (int k = 0; k < 4; k++) begin
      g[k] = mk_frame($urandom, 8'd0);
      push(1'b1, 1'b0, 1'b0, g[k], $urandom_range(1, 15));
    end
    cfg_period_ms = 16'd6;
    @(negedge ACLK); cfg_enable = 1'b1;
    wait_irq(i0, 300, "t2_irq0");
    model_good(g[0]); check_outputs("t2_rd0"); ic = irq_cyc;
    wait_start(s0 + 2, 300, "t2_s2");
    check_rng("t2_gap6a", start_cyc - ic, 51, 60);
    wait_irq(i0 + 1, 300, "t2_irq1");
    model_good(g[1]); check_outputs("t2_rd1");
    cfg_period_ms = 16'd2; ic = irq_cyc;
    wait_start(s0 + 3, 300, "t2_s3");
    check_rng("t2_gap6b", start_cyc - ic, 51, 60);
    wait_irq(i0 + 2, 300, "t2_irq2");
    model_good(g[2]); check_outputs("t2_rd2"); ic = irq_cyc;
    wait_start(s0 + 4, 300, "t2_s4");
    check_rng("t2_gap_clamp", start_cyc - ic, 31, 40);

    // enable drops during WAIT: attempt completes, then idle
    @(negedge ACLK); cfg_enable = 1'b0;
    wait_irq(i0 + 3, 300, "t5_irq");
    model_good(g[3]); check_outputs("t5_rd");
    repeat (80) @(negedge ACLK);
    #1;
    check("t5_no_restart", 64'(n_start), 64'(s0 + 4));
    check("t5_idle_busy", sts_busy, 1'b0);
    check("t5_irq_total", 64'(irq_cnt), 64'(i0 + 4));

    // async reset mid-WAIT
    push(1'b0, 1'b0, 1'b0, 40'd0, 0);
    s0 = n_start;
    pulse_oneshot();
    wait_start(s0 + 1, 100, "t5_rst");
    repeat (3) @(negedge ACLK);
    #1;
    check("t5_busy_wait", sts_busy, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    e_hi = 8'd0; e_hd = 8'd0; e_ti = 8'd0; e_td = 8'd0; e_err = 8'd0;
    e_valid = 1'b0; e_fail = 1'b0;
    check_outputs("t5_async_rst");
    check("t5_rst_busy", sts_busy, 1'b0);
    check("t5_rst_start", eng_start, 1'b0);
    repeat (5) @(negedge ACLK);
    #1;
    check("t5_rst_nostart", 64'(n_start), 64'(s0 + 1));
    @(negedge ACLK); ARESETN = 1'b1;

    // done coincident with the timeout tick
    s0 = n_start; i0 = irq_cnt;
    d = mk_frame($urandom, 8'd0);
    push(1'b1, 1'b1, 1'b0, d, 0);
    pulse_oneshot();
    wait_irq(i0, 300, "t6");
    check("t6_irq_lat", 64'(irq_cyc - done_cyc), 64'd2);
    model_good(d); check_outputs("t6");
    check("t6_starts", 64'(n_start), 64'(s0 + 1));

    // two bad frames then a good one
    q_start.delete(); q_done.delete();
    s0 = n_start; i0 = irq_cnt;
    for (int k = 0; k < 2; k++) begin
      kind = 1'($urandom_range(0, 1));
      if (kind) push(1'b1, 1'b0, 1'b1, mk_frame($urandom, 8'd0), $urandom_range(1, 15));
      else push(1'b1, 1'b0, 1'b0, mk_frame($urandom, 8'($urandom_range(1, 255))), $urandom_range(1, 15));
    end
    d = mk_frame($urandom, 8'd0);
    push(1'b1, 1'b0, 1'b0, d, $urandom_range(1, 15));
    pulse_oneshot();
    wait_irq(i0, 400, "t3");
    model_errs(2); model_good(d); check_outputs("t3");
    check("t3_starts", 64'(n_start), 64'(s0 + 3));
    repeat (2) @(negedge ACLK);
    #1;
    check("t3_irq_once", 64'(irq_cnt), 64'(i0 + 1));
    check_rng("t3_hold1", q_start[1] - q_done[0], 14, 23);
    check_rng("t3_hold2", q_start[2] - q_done[1], 14, 23);

    // engine never answers: four timed-out attempts, then exhaustion
    q_start.delete();
    s0 = n_start; i0 = irq_cnt;
    for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 1'b0, 40'd0, 0);
    pulse_oneshot();
    wait_irq(i0, 600, "t4");
    model_errs(4); e_fail = 1'b1;
    check_outputs("t4");
    check("t4_starts", 64'(n_start), 64'(s0 + 4));
    for (int k = 0; k < 3; k++) check_rng("t4_retry_gap", q_start[k + 1] - q_start[k], 34, 52);
    one_good("t4_recover", mk_frame($urandom, 8'd0), $urandom_range(1, 15));

    // error counter saturation
    for (int b = 0; b < 64; b++) begin
      i0 = irq_cnt;
      for (int k = 0; k < 4; k++)
        push(1'b1, 1'b0, 1'b0, mk_frame($urandom, 8'($urandom_range(1, 255))), $urandom_range(1, 5));
      pulse_oneshot();
      wait_irq(i0, 400, "sat");
      model_errs(4);
    end
    e_fail = 1'b1;
    check_outputs("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
